// File: rtl/btn_cond_pkg.sv
// Shared widths and debounce state encoding for the button conditioner.
package btn_cond_pkg;

    localparam int CODE_W = 7;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        STABLE_HI = 2'b00,
        COUNT_LO  = 2'b01,
        STABLE_LO = 2'b11,
        COUNT_HI  = 2'b10
    } db_state_e;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One active-low button: 2-flop synchronizer, debounce FSM, one-cycle press strobe.
//
// state     | meaning
// STABLE_HI | released, level accepted
// COUNT_LO  | low seen, counting stable low cycles
// STABLE_LO | pressed, level accepted
// COUNT_HI  | high seen, counting stable high cycles
module debounce_cell
    import btn_cond_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] TERM_CNT = DEBOUNCE_CYCLES - CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic [1:0]       settle_q, settle_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_lo_q, in_lo_d;
    logic             armed_q, armed_d;
    logic             btn_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            settle_q <= '0;
            state_q  <= STABLE_HI;
            cnt_q    <= '0;
            in_lo_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            settle_q <= settle_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_lo_q  <= in_lo_d;
            armed_q  <= armed_d;
        end
    end

    assign btn_lo = ~sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            STABLE_HI: begin
                if (btn_lo) begin
                    state_d = COUNT_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT_LO: begin
                if (!btn_lo) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_LO: begin
                if (!btn_lo) begin
                    state_d = COUNT_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT_HI: begin
                if (btn_lo) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE_HI;
        endcase
    end

    // Synchronizer reset value is a fake "released" level; only arm once a
    // real high sample has propagated through, so a button held across reset
    // must be released and pressed again before it counts.
    always_comb begin
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | (settle_q[1] & (state_q == STABLE_HI) & ~btn_lo);
        in_lo_d  = (state_q == STABLE_LO) || (state_q == COUNT_HI);
        press    = (state_q == STABLE_LO) & ~in_lo_q & armed_q;
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounced set/enter buttons with a code-word capture and valid/ready handoff.
// Optional sticky overrun flag: define BUTTON_CONDITIONER_OVERRUN_EN.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_btn_raw,
    input  logic              enter_btn_raw,
    input  logic [CODE_W-1:0] code_raw,
    output logic              set_pulse,
    output logic              enter_pulse,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              overrun
);

    logic              set_press, enter_press;
    logic [CODE_W-1:0] code_meta_q, code_sync_q;
    logic              set_pulse_q, set_pulse_d;
    logic              enter_pulse_q, enter_pulse_d;
    logic [CODE_W-1:0] code_out_q, code_out_d;
    logic              code_valid_q, code_valid_d;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (set_btn_raw),
        .press   (set_press)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (enter_btn_raw),
        .press   (enter_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_meta_q   <= '1;
            code_sync_q   <= '1;
            set_pulse_q   <= 1'b0;
            enter_pulse_q <= 1'b0;
            code_out_q    <= '0;
            code_valid_q  <= 1'b0;
        end else begin
            code_meta_q   <= code_raw;
            code_sync_q   <= code_meta_q;
            set_pulse_q   <= set_pulse_d;
            enter_pulse_q <= enter_pulse_d;
            code_out_q    <= code_out_d;
            code_valid_q  <= code_valid_d;
        end
    end

    // Capture happens on the same edge that raises set_pulse, so a new press
    // always wins over a transfer completing in that cycle.
    always_comb begin
        set_pulse_d   = set_press;
        enter_pulse_d = enter_press;
        code_out_d    = code_out_q;
        code_valid_d  = code_valid_q;
        if (set_press) begin
            code_out_d   = code_sync_q;
            code_valid_d = 1'b1;
        end else if (code_valid_q && code_ready) begin
            code_valid_d = 1'b0;
        end
    end

`ifdef BUTTON_CONDITIONER_OVERRUN_EN
    logic overrun_q, overrun_d;
    logic lost_code;

    assign lost_code = set_press & code_valid_q & ~code_ready;

    always_comb begin
        overrun_d = overrun_q;
        if (enter_press) overrun_d = 1'b0;
        if (lost_code)   overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign set_pulse   = set_pulse_q;
    assign enter_pulse = enter_pulse_q;
    assign code_out    = code_out_q;
    assign code_valid  = code_valid_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;
    import btn_cond_pkg::*;

`ifdef BUTTON_CONDITIONER_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_btn_raw = 1'b1;
    logic       enter_btn_raw = 1'b1;
    logic [6:0] code_raw = 7'h00;
    logic       code_ready = 1'b0;
    logic       set_pulse, enter_pulse, code_valid, overrun;
    logic [6:0] code_out;

    button_conditioner #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk           (clk),
        .rst           (rst),
        .set_btn_raw   (set_btn_raw),
        .enter_btn_raw (enter_btn_raw),
        .code_raw      (code_raw),
        .set_pulse     (set_pulse),
        .enter_pulse   (enter_pulse),
        .code_out      (code_out),
        .code_valid    (code_valid),
        .code_ready    (code_ready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] code;
        logic       do_set;
        logic       do_enter;
        logic       ready;
        logic       exp_ovr;
    } vec_t;

    vec_t       tbl[8];
    logic [6:0] exp_code_q[$];
    int         ent_pending = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every set press pushes its code; each set_pulse pops one.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (set_pulse === 1'b1) begin
                    if (exp_code_q.size() == 0) begin
                        chk("spurious set_pulse", 32'(set_pulse), 32'd0);
                    end else begin
                        logic [6:0] e;
                        e = exp_code_q.pop_front();
                        chk("sb code_out", 32'(code_out), 32'(e));
                        chk("sb code_valid", 32'(code_valid), 32'd1);
                    end
                end
                if (enter_pulse === 1'b1) begin
                    if (ent_pending == 0) chk("spurious enter_pulse", 32'(enter_pulse), 32'd0);
                    else ent_pending--;
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " set_pulse"}, 32'(set_pulse), 32'd0);
        chk({tag, " enter_pulse"}, 32'(enter_pulse), 32'd0);
        chk({tag, " code_out"}, 32'(code_out), 32'd0);
        chk({tag, " code_valid"}, 32'(code_valid), 32'd0);
        chk({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic do_press(input int r);
        vec_t v;
        int set_lat, ent_lat, nset, nent;
        logic v_at, o_at, got_first, valid_next;
        logic [6:0] code_next;
        v = tbl[r];
        set_lat = 0; ent_lat = 0; nset = 0; nent = 0;
        v_at = 1'b0; o_at = 1'b0; got_first = 1'b0; valid_next = 1'b0; code_next = '0;
        @(posedge clk); #1;
        code_raw   = v.code;
        code_ready = v.ready;
        if (v.do_set)   exp_code_q.push_back(v.code);
        if (v.do_enter) ent_pending++;
        set_btn_raw   = ~v.do_set;
        enter_btn_raw = ~v.do_enter;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            if (i == 10) begin
                #1;
                set_btn_raw   = 1'b1;
                enter_btn_raw = 1'b1;
            end
            @(negedge clk);
            if (v.do_set && set_lat != 0 && i == set_lat + 1) begin
                valid_next = code_valid;
                code_next  = code_out;
            end
            if (set_pulse) begin
                nset++;
                if (set_lat == 0) set_lat = i;
            end
            if (enter_pulse) begin
                nent++;
                if (ent_lat == 0) ent_lat = i;
            end
            if (!got_first && (set_pulse || enter_pulse)) begin
                got_first = 1'b1;
                v_at = code_valid;
                o_at = overrun;
            end
        end
        chk($sformatf("row%0d set pulses", r), 32'(nset), v.do_set ? 32'd1 : 32'd0);
        chk($sformatf("row%0d enter pulses", r), 32'(nent), v.do_enter ? 32'd1 : 32'd0);
        if (v.do_set) begin
            chk($sformatf("row%0d set latency", r), 32'(set_lat), 32'(LAT));
            chk($sformatf("row%0d valid at pulse", r), 32'(v_at), 32'd1);
            chk($sformatf("row%0d valid next", r), 32'(valid_next), v.ready ? 32'd0 : 32'd1);
            chk($sformatf("row%0d code held", r), 32'(code_next), 32'(v.code));
        end
        if (v.do_enter) chk($sformatf("row%0d enter latency", r), 32'(ent_lat), 32'(LAT));
        if (v.do_set && v.do_enter)
            chk($sformatf("row%0d same-cycle pulses", r), 32'(set_lat), 32'(ent_lat));
        chk($sformatf("row%0d overrun", r), 32'(o_at), 32'(v.exp_ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        tbl[0] = '{code: 7'h2A, do_set: 1'b1, do_enter: 1'b0, ready: 1'b0, exp_ovr: 1'b0};
        tbl[1] = '{code: 7'h15, do_set: 1'b1, do_enter: 1'b0, ready: 1'b0, exp_ovr: OVR};
        tbl[2] = '{code: 7'h15, do_set: 1'b0, do_enter: 1'b1, ready: 1'b0, exp_ovr: 1'b0};
        tbl[3] = '{code: 7'h33, do_set: 1'b1, do_enter: 1'b1, ready: 1'b0, exp_ovr: 1'b0};
        tbl[4] = '{code: 7'h7F, do_set: 1'b1, do_enter: 1'b0, ready: 1'b1, exp_ovr: 1'b0};
        tbl[5] = '{code: 7'h0C, do_set: 1'b1, do_enter: 1'b0, ready: 1'b0, exp_ovr: 1'b0};
        tbl[6] = '{code: 7'h0C, do_set: 1'b0, do_enter: 1'b1, ready: 1'b0, exp_ovr: 1'b0};
        tbl[7] = '{code: 7'h55, do_set: 1'b1, do_enter: 1'b0, ready: 1'b0, exp_ovr: 1'b0};

        fork
            monitor();
        join_none

        #12;
        check_idle_outputs("in reset");
        #10 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("after reset");

        // Two-cycle glitch on enter must be rejected.
        @(posedge clk); #1 enter_btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1 enter_btn_raw = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (enter_pulse) n++;
        end
        chk("glitch enter pulses", 32'(n), 32'd0);
        chk("glitch enter state", 32'(dut.u_enter.state_q), 32'(STABLE_HI));

        for (int r = 0; r < 8; r++) begin
            if (r == 3) begin
                // One-cycle handshake on the pending code 0x15.
                @(negedge clk);
                chk("hs valid before", 32'(code_valid), 32'd1);
                @(posedge clk); #1 code_ready = 1'b1;
                @(posedge clk); #1 code_ready = 1'b0;
                @(negedge clk);
                chk("hs valid after", 32'(code_valid), 32'd0);
                chk("hs code kept", 32'(code_out), 32'h15);
            end
            if (r == 7) begin
                // Reset mid-count with the button held low, pending code outstanding.
                @(negedge clk);
                chk("pre-rst valid", 32'(code_valid), 32'd1);
                @(posedge clk); #1;
                code_raw    = 7'h55;
                set_btn_raw = 1'b0;
                repeat (4) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check_idle_outputs("mid-count rst");
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                n = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (set_pulse) n++;
                end
                chk("held after rst pulses", 32'(n), 32'd0);
                chk("held after rst valid", 32'(code_valid), 32'd0);
                @(posedge clk); #1 set_btn_raw = 1'b1;
                repeat (15) @(posedge clk);
                @(negedge clk);
                chk("released after rst valid", 32'(code_valid), 32'd0);
            end
            do_press(r);
        end

        chk("scoreboard drained", 32'(exp_code_q.size()), 32'd0);
        chk("enter scoreboard drained", 32'(ent_pending), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd1000, the number of consecutive stable cycles (range 2..65535) needed to accept a button level change.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port set_btn_raw  input  1  asynchronous set-password button, active-low.
REQ-005 SHALL have port enter_btn_raw  input  1  asynchronous enter/unlock button, active-low.
REQ-006 SHALL have port code_raw  input  7  asynchronous switch code word.
REQ-007 SHALL have port set_pulse  output  1  one-cycle strobe per accepted set press.
REQ-008 SHALL have port enter_pulse  output  1  one-cycle strobe per accepted enter press.
REQ-009 SHALL have port code_out  output  7  code captured at set press.
REQ-010 SHALL have port code_valid  output  1  code_out valid, held until accepted.
REQ-011 SHALL have port code_ready  input  1  consumer accepts code_out.
REQ-012 SHALL have port overrun  output  1  sticky lost-code flag (see Configuration).

Function
REQ-013 SHALL pass each button and each code bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each button with an FSM: STABLE_HI, COUNT_LO, STABLE_LO, COUNT_HI; 16-bit counter.
REQ-015 SHALL, in STABLE_x, go to COUNT_y with counter=1 when the synced level differs from x; otherwise stay, counter=0.
REQ-016 SHALL, in COUNT_y, return to STABLE_x with counter=0 if the synced level reverts to x; increment if not; enter STABLE_y when counter reaches DEBOUNCE_CYCLES-1.
REQ-017 SHALL assert the pulse for exactly one cycle on the STABLE_HI to STABLE_LO transition (press); release produces no pulse.
REQ-018 SHALL have latency from raw press edge to pulse of 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, fixed.
REQ-019 SHALL, on set_pulse, load code_out with the synchronized code word and set code_valid=1 in the same cycle as the pulse.
REQ-020 SHALL complete a transfer on a cycle with code_valid and code_ready both high; code_valid clears the next cycle unless a new set_pulse occurs that cycle.
REQ-021 SHALL, on set_pulse with code_valid=1 and code_ready=0, overwrite code_out, keep code_valid=1 and flag an overrun.
REQ-022 SHALL, on set_pulse coinciding with a completing transfer, load the new code, keep code_valid=1 and not flag overrun.
REQ-023 SHALL emit set_pulse and enter_pulse independently; simultaneous pulses are both output in the same cycle.
REQ-024 SHALL hold code_out stable while code_valid=1 except per REQ-021.

Reset
REQ-025 SHALL, on rst, asynchronously set synchronizer flops to 1, debouncers to STABLE_HI with counter 0, and all outputs to 0.
REQ-026 SHALL, when rst asserts mid-count or mid-handshake, drop the pending code; it does not reappear after reset.
REQ-027 SHALL produce no spurious pulse on reset release while the buttons are held pressed; a press is accepted only after release and re-press.

Configuration
REQ-028 SHALL, with BUTTON_CONDITIONER_OVERRUN_EN defined, drive overrun as a sticky flag: set per REQ-021 and cleared on enter_pulse or rst.
REQ-029 SHALL, without BUTTON_CONDITIONER_OVERRUN_EN, tie overrun to 0 while keeping the overwrite behaviour of REQ-021 unchanged.

Structure
REQ-030 SHALL take CODE_W=7, the debounce counter width 16 and the debounce state encoding from the shared package btn_cond_pkg.
REQ-031 SHALL implement synchronizer, debounce FSM and press pulse in sub-module debounce_cell, instantiated once per button.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SHALL check: set_btn_raw held low 10 cycles, code_raw=7'h2A -> set_pulse exactly once, 7 cycles after the edge; code_out=7'h2A; code_valid=1.
REQ-033 SHALL check: enter_btn_raw glitches low for 2 cycles, then high -> no enter_pulse; debouncer back in STABLE_HI.
REQ-034 SHALL check: code_valid=1 with code_ready=1 for one cycle -> code_valid=0 the next cycle; code_out unchanged.
REQ-035 SHALL check: second press with code 7'h15 while code_ready=0 -> code_out=7'h15, code_valid=1, overrun=1 (macro on) or 0 (macro off); a following enter press clears overrun.
REQ-036 SHALL check: both buttons pressed the same cycle -> set_pulse and enter_pulse high the same cycle.
REQ-037 SHALL check: rst pulsed while COUNT_LO with the button held low -> all outputs 0; no pulse until the button is released and pressed again.
